// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
// Shared encodings for the sequential multiply/divide unit:
//   - op_e        : operation select driven on muldiv_seq.op
//   - state_e     : muldiv_seq FSM state encoding
//   - step_mode_e : selects the multiply or divide iteration in muldiv_step
//   - MULDIV_ITERS: default operand width, which is also the RUN iteration count
// -----------------------------------------------------------------------------
package muldiv_pkg;

  localparam int unsigned MULDIV_ITERS = 32;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PREP = 3'd1,
    ST_RUN  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  typedef enum logic {
    STEP_MUL = 1'b0,
    STEP_DIV = 1'b1
  } step_mode_e;

endpackage

// File: rtl/muldiv_step.sv
// -----------------------------------------------------------------------------
// muldiv_step
// One combinational iteration of the shift-add multiplier or the restoring
// shift-subtract divider.
//   mode_i   : STEP_MUL or STEP_DIV
//   acc_i    : running upper accumulator (partial product / partial remainder)
//   opnd_i   : multiplicand (MUL) or divisor (DIV)
//   in_bit_i : MUL - current multiplier LSB (add enable)
//              DIV - dividend MSB shifted into the remainder
//   acc_o    : next accumulator
//   bit_o    : MUL - bit shifted out into the top of the low register
//              DIV - quotient bit shifted into the bottom of the low register
// -----------------------------------------------------------------------------
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = MULDIV_ITERS
) (
  input  step_mode_e       mode_i,
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] opnd_i,
  input  logic             in_bit_i,
  output logic [WIDTH-1:0] acc_o,
  output logic             bit_o
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             ge;

  always_comb begin
    sum     = {1'b0, acc_i} + (in_bit_i ? {1'b0, opnd_i} : '0);
    shifted = {acc_i, in_bit_i};
    ge      = (shifted >= {1'b0, opnd_i});
    // When ge holds the true difference is below the divisor, so the low
    // WIDTH bits carry it exactly.
    diff    = shifted[WIDTH-1:0] - opnd_i;
    acc_o   = acc_i;
    bit_o   = 1'b0;
    if (mode_i == STEP_MUL) begin
      acc_o = sum[WIDTH:1];
      bit_o = sum[0];
    end else if (ge) begin
      acc_o = diff;
      bit_o = 1'b1;
    end else begin
      acc_o = shifted[WIDTH-1:0];
      bit_o = 1'b0;
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// -----------------------------------------------------------------------------
// muldiv_seq
// Sequential MIPS-style multiply/divide unit with architectural HI/LO.
// Latency: done pulses WIDTH+3 cycles after the accepting edge (PREP, WIDTH
// RUN cycles, FIX, DONE); divide-by-zero finishes straight from PREP.
// Optional feature: define MULDIV_SIGNED_EN for signed MULT/DIV; otherwise
// op[0] is ignored and every operation is unsigned.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   start, op, a, b : operation request (sampled in IDLE only)
//   hi_we, lo_we,
//   wdata           : MTHI/MTLO writes, honoured in IDLE and DONE
//   hi, lo          : HI/LO registers
//   busy            : high in PREP, RUN and FIX
//   done            : one-cycle completion pulse (DONE state)
//   dbz             : divide-by-zero, meaningful while done=1
// WIDTH must be at least 2.
// -----------------------------------------------------------------------------
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = MULDIV_ITERS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             dbz
);

  localparam int unsigned    CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic             is_div_q, is_div_d;
  logic [WIDTH-1:0] a_q, a_d;     // dividend/multiplier, then quotient/product low half
  logic [WIDTH-1:0] b_q, b_d;     // divisor/multiplicand
  logic [WIDTH-1:0] acc_q, acc_d; // remainder/product high half
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             dbz_q, dbz_d;

`ifdef MULDIV_SIGNED_EN
  logic                      sgn_q, sgn_d;
  logic                      neg_q, neg_d;   // negate product / quotient
  logic                      negr_q, negr_d; // negate remainder
  logic signed [2*WIDTH-1:0] prod;
`else
  logic unused_op0;
  assign unused_op0 = op[0];
`endif

  logic [WIDTH-1:0] step_acc;
  logic             step_bit;
  step_mode_e       step_mode;
  logic             step_in;

  assign step_mode = is_div_q ? STEP_DIV : STEP_MUL;
  assign step_in   = is_div_q ? a_q[WIDTH-1] : a_q[0];

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .mode_i   (step_mode),
    .acc_i    (acc_q),
    .opnd_i   (b_q),
    .in_bit_i (step_in),
    .acc_o    (step_acc),
    .bit_o    (step_bit)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start) state_d = ST_PREP;
      ST_PREP: state_d = (is_div_q && (b_q == '0)) ? ST_DONE : ST_RUN;
      ST_RUN:  if (cnt_q == CNT_LAST) state_d = ST_FIX;
      ST_FIX:  state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = (state_q == ST_PREP) || (state_q == ST_RUN) || (state_q == ST_FIX);
    done = (state_q == ST_DONE);
  end

  // Datapath next-state
  always_comb begin
    is_div_d = is_div_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dbz_d    = 1'b0;
`ifdef MULDIV_SIGNED_EN
    sgn_d    = sgn_q;
    neg_d    = neg_q;
    negr_d   = negr_q;
    prod     = '0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          is_div_d = op[1];
          a_d      = a;
          b_d      = b;
`ifdef MULDIV_SIGNED_EN
          sgn_d    = op[0];
`endif
        end
        // Same-cycle write with an accepted start lands now and is
        // overwritten in FIX.
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
      end
      ST_PREP: begin
        acc_d = '0;
        cnt_d = '0;
        dbz_d = is_div_q && (b_q == '0);
`ifdef MULDIV_SIGNED_EN
        neg_d  = 1'b0;
        negr_d = 1'b0;
        if (sgn_q) begin
          if (a_q[WIDTH-1]) a_d = -a_q;
          if (b_q[WIDTH-1]) b_d = -b_q;
          neg_d  = a_q[WIDTH-1] ^ b_q[WIDTH-1];
          negr_d = is_div_q & a_q[WIDTH-1];
        end
`endif
      end
      ST_RUN: begin
        acc_d = step_acc;
        a_d   = is_div_q ? {a_q[WIDTH-2:0], step_bit} : {step_bit, a_q[WIDTH-1:1]};
        cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
      end
      ST_FIX: begin
        // {acc, a} is {product hi, lo} for multiply and {remainder, quotient}
        // for divide, so both map acc->hi and a->lo.
        hi_d = acc_q;
        lo_d = a_q;
`ifdef MULDIV_SIGNED_EN
        if (is_div_q) begin
          if (neg_q)  lo_d = -a_q;
          if (negr_q) hi_d = -acc_q;
        end else if (neg_q) begin
          prod = -$signed({acc_q, a_q});
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end
`endif
      end
      ST_DONE: begin
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      is_div_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      dbz_q    <= 1'b0;
`ifdef MULDIV_SIGNED_EN
      sgn_q    <= 1'b0;
      neg_q    <= 1'b0;
      negr_q   <= 1'b0;
`endif
    end else begin
      is_div_q <= is_div_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      dbz_q    <= dbz_d;
`ifdef MULDIV_SIGNED_EN
      sgn_q    <= sgn_d;
      neg_q    <= neg_d;
      negr_q   <= negr_d;
`endif
    end
  end

  assign hi  = hi_q;
  assign lo  = lo_q;
  assign dbz = dbz_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// -----------------------------------------------------------------------------
// tb_muldiv_seq
// Directed testbench for muldiv_seq (WIDTH=32). Expected values for signed
// operations follow MULDIV_SIGNED_EN when the bench is built with it.
// -----------------------------------------------------------------------------
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        hi_we, lo_we;
  logic [31:0] wdata;
  logic [31:0] hi, lo;
  logic        busy, done, dbz;

  int n_tot = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  muldiv_seq #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .wdata (wdata),
    .hi    (hi),
    .lo    (lo),
    .busy  (busy),
    .done  (done),
    .dbz   (dbz)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Issue one operation, scramble the inputs after acceptance, optionally
  // write HI=0x55 after wr_at edges, and wait (bounded) for done.
  // lat is the cycle of done counted from the accepting edge N.
  task automatic do_op(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                       input int wr_at, output int lat, output int bcnt, output logic dz);
    int edges;
    @(negedge clk);
    start = 1'b1; op = o; a = av; b = bv;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; op = ~o; a = ~av; b = ~bv;
    edges = 0;
    bcnt  = 0;
    while (done !== 1'b1 && edges < 100) begin
      if (busy === 1'b1) bcnt++;
      hi_we = (edges == wr_at);
      wdata = 32'h55;
      @(posedge clk);
      edges++;
      @(negedge clk);
      hi_we = 1'b0;
    end
    lat = edges + 1;
    dz  = dbz;
    chk("busy_at_done", {63'd0, busy}, 64'd0);
    // start offered while in DONE must not launch a new operation
    start = 1'b1; op = o; a = av; b = bv;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("start_in_done_ignored", {63'd0, busy}, 64'd0);
    chk("done_one_cycle", {63'd0, done}, 64'd0);
  endtask

  initial begin
    int   lat, bcnt, edges, npulse;
    logic dz;

    rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_hi",   {32'd0, hi}, 64'd0);
    chk("rst_lo",   {32'd0, lo}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_dbz",  {63'd0, dbz}, 64'd0);
    rst = 1'b0;

    // MULTU max*max
    do_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, lat, bcnt, dz);
    chk("multu_hi",   {32'd0, hi}, 64'hFFFF_FFFE);
    chk("multu_lo",   {32'd0, lo}, 64'h0000_0001);
    chk("multu_lat",  64'(lat), 64'd35);
    chk("multu_busy", 64'(bcnt), 64'd34);
    chk("multu_dbz",  {63'd0, dz}, 64'd0);

    // MULT -3 * 7
    do_op(2'b01, 32'hFFFF_FFFD, 32'd7, -1, lat, bcnt, dz);
`ifdef MULDIV_SIGNED_EN
    chk("mult_hi", {32'd0, hi}, 64'hFFFF_FFFF);
`else
    chk("mult_hi", {32'd0, hi}, 64'h0000_0006);
`endif
    chk("mult_lo",  {32'd0, lo}, 64'hFFFF_FFEB);
    chk("mult_lat", 64'(lat), 64'd35);

    // DIV -7 / 2
    do_op(2'b11, 32'hFFFF_FFF9, 32'd2, -1, lat, bcnt, dz);
`ifdef MULDIV_SIGNED_EN
    chk("div_lo", {32'd0, lo}, 64'hFFFF_FFFD);
    chk("div_hi", {32'd0, hi}, 64'hFFFF_FFFF);
`else
    chk("div_lo", {32'd0, lo}, 64'h7FFF_FFFC);
    chk("div_hi", {32'd0, hi}, 64'h0000_0001);
`endif
    chk("div_lat", 64'(lat), 64'd35);

    // DIVU 100 / 7
    do_op(2'b10, 32'd100, 32'd7, -1, lat, bcnt, dz);
    chk("divu_lo",  {32'd0, lo}, 64'd14);
    chk("divu_hi",  {32'd0, hi}, 64'd2);
    chk("divu_dbz", {63'd0, dz}, 64'd0);

    // DIV most-negative / -1
    do_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, -1, lat, bcnt, dz);
`ifdef MULDIV_SIGNED_EN
    chk("divovf_lo", {32'd0, lo}, 64'h8000_0000);
    chk("divovf_hi", {32'd0, hi}, 64'h0000_0000);
`else
    chk("divovf_lo", {32'd0, lo}, 64'h0000_0000);
    chk("divovf_hi", {32'd0, hi}, 64'h8000_0000);
`endif
    chk("divovf_dbz", {63'd0, dz}, 64'd0);

    // IDLE writes, then divide by zero leaves them untouched
    @(negedge clk);
    hi_we = 1'b1; wdata = 32'h11;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h22;
    @(negedge clk);
    lo_we = 1'b0;
    chk("mthi_idle", {32'd0, hi}, 64'h11);
    chk("mtlo_idle", {32'd0, lo}, 64'h22);
    do_op(2'b10, 32'd100, 32'd0, -1, lat, bcnt, dz);
    chk("dbz_lat",  64'(lat), 64'd2);
    chk("dbz_flag", {63'd0, dz}, 64'd1);
    chk("dbz_busy", 64'(bcnt), 64'd1);
    chk("dbz_hi",   {32'd0, hi}, 64'h11);
    chk("dbz_lo",   {32'd0, lo}, 64'h22);

    // HI write during RUN is ignored; in IDLE it lands next cycle
    do_op(2'b00, 32'd3, 32'd5, 5, lat, bcnt, dz);
    chk("wrrun_hi", {32'd0, hi}, 64'd0);
    chk("wrrun_lo", {32'd0, lo}, 64'd15);
    @(negedge clk);
    hi_we = 1'b1; wdata = 32'h55;
    @(negedge clk);
    hi_we = 1'b0;
    chk("wridle_hi", {32'd0, hi}, 64'h55);

    // LO write in the same cycle as an accepted start
    @(negedge clk);
    start = 1'b1; op = 2'b00; a = 32'd2; b = 32'd3; lo_we = 1'b1; wdata = 32'h77;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; lo_we = 1'b0;
    chk("wrstart_lo_now", {32'd0, lo}, 64'h77);
    edges = 0;
    while (done !== 1'b1 && edges < 100) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    chk("wrstart_lat", 64'(edges + 1), 64'd35);
    chk("wrstart_lo",  {32'd0, lo}, 64'd6);
    chk("wrstart_hi",  {32'd0, hi}, 64'd0);

    // Reset during the 10th RUN cycle aborts without a done pulse
    @(negedge clk);
    start = 1'b1; op = 2'b10; a = 32'd100; b = 32'd7;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (10) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_hi",   {32'd0, hi}, 64'd0);
    chk("abort_lo",   {32'd0, lo}, 64'd0);
    npulse = 0;
    repeat (40) begin
      if (done === 1'b1) npulse++;
      @(posedge clk);
      @(negedge clk);
    end
    chk("abort_no_done", 64'(npulse), 64'd0);
    do_op(2'b10, 32'd100, 32'd7, -1, lat, bcnt, dz);
    chk("after_abort_lo",  {32'd0, lo}, 64'd14);
    chk("after_abort_hi",  {32'd0, hi}, 64'd2);
    chk("after_abort_lat", 64'(lat), 64'd35);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
